// File: rtl/vga_plot_arbiter_pkg.sv
// Shared types and constants for the VGA plot-port arbiter.
//   SCREEN_W/SCREEN_H : visible raster size
//   X_W/Y_W/C_W       : default coordinate and colour widths
//   arb_state_t       : arbiter FSM states
//   vga_pixel_t       : one plot-port beat
package vga_plot_arbiter_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned C_W      = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] colour;
    logic           plot;
  } vga_pixel_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   last   : index served most recently
//   winner : first set req bit searching last+1, last+2, ... (mod N_REQ)
//   valid  : at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx    = '0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((32'(last) + k) % N_REQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares one VGA adapter plot port between N_REQ drawing engines.
//   clk, rst            : clock and async active-high reset
//   req                 : engine i wants the port
//   eng_done/eng_plot   : per-engine done and plot strobes
//   eng_x/eng_y/eng_col : packed per-engine pixel fields
//   gnt                 : one-hot grant, doubles as engine start
//   vga_*               : muxed plot port to the adapter (combinational)
//   busy                : a grant is active
//   timeout             : one-cycle pulse when the watchdog reclaims the port
module vga_plot_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned X_W     = vga_plot_arbiter_pkg::X_W,
  parameter int unsigned Y_W     = vga_plot_arbiter_pkg::Y_W,
  parameter int unsigned C_W     = vga_plot_arbiter_pkg::C_W,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned TO_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       eng_done,
  input  logic [N_REQ-1:0]       eng_plot,
  input  logic [N_REQ*X_W-1:0]   eng_x,
  input  logic [N_REQ*Y_W-1:0]   eng_y,
  input  logic [N_REQ*C_W-1:0]   eng_colour,
  output logic [N_REQ-1:0]       gnt,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   timeout
);

  import vga_plot_arbiter_pkg::*;

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic             busy_q;
  logic             timeout_q;
  logic [TO_W-1:0]  wd_q;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] win_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  // Arbiter FSM with watchdog; RELEASE gives the engine a start-low cycle to clear done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      win_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= GRANT;
            win_q   <= pick_idx;
            gnt_q   <= N_REQ'(1) << pick_idx;
            busy_q  <= 1'b1;
            wd_q    <= '0;
          end
        end
        GRANT: begin
          // done wins over a coincident watchdog expiry
          if (eng_done[win_q]) begin
            state_q <= RELEASE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
            state_q   <= RELEASE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        RELEASE: begin
          state_q <= IDLE;
          last_q  <= win_q;
          wd_q    <= '0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Zero-latency plot mux; only the granted engine reaches the adapter.
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    if (state_q == GRANT) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (win_q == IDX_W'(i)) begin
          vga_x      = eng_x[i*X_W +: X_W];
          vga_y      = eng_y[i*Y_W +: Y_W];
          vga_colour = eng_colour[i*C_W +: C_W];
          vga_plot   = eng_plot[i];
        end
      end
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized scoreboard bench for vga_plot_arbiter plus directed reset and full-screen fill cases.
module tb_vga_plot_arbiter;

  localparam int N  = 3;
  localparam int TO = 50;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, eng_done, eng_plot;
  logic [N*8-1:0] eng_x;
  logic [N*7-1:0] eng_y;
  logic [N*3-1:0] eng_colour;
  logic [N-1:0]   gnt;
  logic [7:0]     vga_x;
  logic [6:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot, busy, timeout;

  logic [N-1:0]   f_req, f_done, f_plot;
  logic [N*8-1:0] f_x;
  logic [N*7-1:0] f_y;
  logic [N*3-1:0] f_c;
  logic [N-1:0]   f_gnt;
  logic [7:0]     f_vga_x;
  logic [6:0]     f_vga_y;
  logic [2:0]     f_vga_colour;
  logic           f_vga_plot, f_busy, f_timeout;

  vga_plot_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .C_W(3), .TIMEOUT(TO), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .eng_done(eng_done), .eng_plot(eng_plot),
    .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour), .gnt(gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .timeout(timeout)
  );

  vga_plot_arbiter #(.N_REQ(N), .X_W(8), .Y_W(7), .C_W(3), .TIMEOUT(20000), .TO_W(16)) dut_fill (
    .clk(clk), .rst(rst), .req(f_req), .eng_done(f_done), .eng_plot(f_plot),
    .eng_x(f_x), .eng_y(f_y), .eng_colour(f_c), .gnt(f_gnt),
    .vga_x(f_vga_x), .vga_y(f_vga_y), .vga_colour(f_vga_colour), .vga_plot(f_vga_plot),
    .busy(f_busy), .timeout(f_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int eng;
    int len;
    int to;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference round-robin: first requester after 'last', wrapping.
  function automatic int rr_model(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  logic           mon_en = 1'b0;
  logic [N-1:0]   m_g, prev_g, prev_req;
  int             prev_run, m_last, m_win, m_len, m_w;
  exp_t           m_e;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_run = 2;
      prev_g   = '0;
      prev_req = req;
      m_last   = N - 1;
      m_win    = 0;
      m_len    = 0;
    end else begin
      m_g = gnt;
      chk("busy", int'(busy), int'(m_g != 0));
      chk("onehot", int'(m_g == 0 || $onehot(m_g)), 1);
      if (prev_g != 0) begin
        if (m_g != 0) chk("gnt_hold", int'(m_g), int'(prev_g));
        else if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: release with no expected grant at %0t", $time);
        end else begin
          m_e = sb_q.pop_front();
          chk("rel_engine", m_win, m_e.eng);
          chk("grant_len", m_len, m_e.len);
          chk("timeout_pulse", int'(timeout), m_e.to);
          m_last = m_win;
        end
      end else if (prev_run == 1) begin
        chk("release_gap", int'(m_g), 0);
      end else begin
        m_w = rr_model(prev_req, m_last);
        if (m_w < 0) chk("idle_no_gnt", int'(m_g), 0);
        else begin
          chk("grant_pick", int'(m_g), 1 << m_w);
          m_win = m_w;
          m_len = 0;
        end
      end
      if (!(prev_g != 0 && m_g == 0)) chk("timeout_low", int'(timeout), 0);
      if (m_g != 0) begin
        m_len++;
        chk("vga_x", int'(vga_x), int'(eng_x[m_win*8 +: 8]));
        chk("vga_y", int'(vga_y), int'(eng_y[m_win*7 +: 7]));
        chk("vga_colour", int'(vga_colour), int'(eng_colour[m_win*3 +: 3]));
        chk("vga_plot", int'(vga_plot), int'(eng_plot[m_win]));
      end else begin
        chk("vga_idle", int'({vga_x, vga_y, vga_colour, vga_plot}), 0);
      end
      prev_run = (m_g == 0) ? ((prev_run < 100) ? prev_run + 1 : 100) : 0;
      prev_g   = m_g;
      prev_req = req;
    end
  end

  // ---------------- engine driver ----------------
  int   gc[N];
  int   dur[N];
  exp_t d_e;

  task automatic drive_cycle();
    for (int i = 0; i < N; i++) begin
      eng_x[i*8 +: 8]      = 8'($urandom_range(0, 159));
      eng_y[i*7 +: 7]      = 7'($urandom_range(0, 119));
      eng_colour[i*3 +: 3] = 3'($urandom);
      eng_plot[i]          = 1'($urandom);
      if (gnt[i]) begin
        gc[i]++;
        if (gc[i] == 1) begin
          case ($urandom % 10)
            0:       dur[i] = TO;
            1:       dur[i] = TO - 1;
            2:       dur[i] = ($urandom % 2 == 0) ? TO + 1 : 1000;
            default: dur[i] = 1 + int'($urandom % 12);
          endcase
          d_e.eng = i;
          d_e.len = (dur[i] < TO) ? dur[i] : TO;
          d_e.to  = (dur[i] > TO) ? 1 : 0;
          sb_q.push_back(d_e);
        end
        eng_done[i] = (gc[i] == dur[i]);
        if ($urandom % 4 == 0) req[i] = ~req[i];
      end else begin
        gc[i]       = 0;
        eng_done[i] = ($urandom % 4 == 0);
        if (req[i]) req[i] = ($urandom % 100 < 85);
        else        req[i] = ($urandom % 100 < 30);
      end
    end
  endtask

  int n, fill_pix, fill_err, fill_to, ex, ey;
  bit seen, done_ok;

  initial begin
    rst = 1'b1;
    req = '0; eng_done = 3'b111; eng_plot = 3'b111;
    eng_x = '1; eng_y = '1; eng_colour = '1;
    f_req = '0; f_done = '0; f_plot = '0; f_x = '0; f_y = '0; f_c = '0;
    for (int i = 0; i < N; i++) begin gc[i] = 0; dur[i] = 0; end

    // reset state: outputs quiet even with every engine strobing
    #12;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_vga_plot", int'(vga_plot), 0);

    // first grant after reset goes to engine 0, mux follows it only
    @(posedge clk); #1;
    rst = 1'b0; eng_done = '0; req = 3'b001;
    eng_x = {8'd99, 8'd99, 8'd5};
    eng_y = {7'd99, 7'd99, 7'd7};
    eng_colour = {3'd6, 3'd6, 3'd3};
    eng_plot = 3'b111;
    @(posedge clk); #1;
    chk("t1_gnt", int'(gnt), 1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_vga_x", int'(vga_x), 5);
    chk("t1_vga_y", int'(vga_y), 7);
    chk("t1_vga_colour", int'(vga_colour), 3);
    chk("t1_vga_plot", int'(vga_plot), 1);
    eng_done = 3'b110;
    @(posedge clk); #1;
    chk("t1_ignore_done", int'(gnt), 1);
    eng_done = 3'b001;
    @(posedge clk); #1;
    chk("t1_release_gnt", int'(gnt), 0);
    chk("t1_release_busy", int'(busy), 0);
    chk("t1_release_plot", int'(vga_plot), 0);
    eng_done = '0; req = '0;

    // randomized traffic against the scoreboard
    @(posedge clk); #1;
    rst = 1'b1; req = '0; eng_done = '0; eng_plot = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (3000) begin
      @(posedge clk); #1;
      drive_cycle();
    end
    mon_en = 1'b0;
    sb_q.delete();

    // reset mid-grant clears gnt and the plot strobe before the next edge
    @(posedge clk); #1;
    rst = 1'b1; req = '0; eng_done = '0;
    #2 rst = 1'b0;
    req = 3'b100; eng_plot = 3'b100;
    @(posedge clk); #1;
    chk("t6_gnt", int'(gnt), 4);
    chk("t6_plot", int'(vga_plot), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_gnt", int'(gnt), 0);
    chk("t6_rst_plot", int'(vga_plot), 0);
    chk("t6_rst_busy", int'(busy), 0);
    rst = 1'b0; req = 3'b111;
    @(posedge clk); #1;
    chk("t6_first_after_rst", int'(gnt), 1);
    req = '0; eng_plot = '0;

    // full 160x120 fill on the default-watchdog instance
    n = 0; fill_pix = 0; fill_err = 0; fill_to = 0; seen = 0; done_ok = 0; ex = 0; ey = 0;
    f_req = 3'b001;
    for (int c = 0; c < 20100 && !done_ok; c++) begin
      @(posedge clk); #1;
      if (f_gnt[0]) begin
        seen  = 1;
        f_req = '0;
        n++;
        ex = (n - 1) % 160;
        ey = (n - 1) / 160;
        f_x[7:0] = 8'(ex);
        f_y[6:0] = 7'(ey);
        f_c[2:0] = 3'(n);
        f_plot   = 3'b001;
        f_done   = (n == 19200) ? 3'b001 : 3'b000;
      end else begin
        f_plot = '0;
        f_done = '0;
        if (seen) done_ok = 1;
      end
      @(negedge clk);
      if (f_timeout) fill_to++;
      if (f_vga_plot) begin
        fill_pix++;
        if (int'(f_vga_x) != ex || int'(f_vga_y) != ey) fill_err++;
      end
    end
    chk("fill_done", int'(done_ok), 1);
    chk("fill_pixels", fill_pix, 19200);
    chk("fill_coord_errs", fill_err, 0);
    chk("fill_timeout", fill_to, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
